// File: rtl/roi_address_generator.sv
// Raster-scan address generator for a rectangular, decimated region of interest
// inside a frame buffer, with ready/valid handshake, frame markers and restart.
module roi_address_generator #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int BASE_ADDR    = 0,
  parameter int STEP_BITS    = 3,
  localparam int ADDR_BITS   = $clog2(BASE_ADDR + IMAGE_WIDTH * IMAGE_HEIGHT),
  localparam int X_BITS      = $clog2(IMAGE_WIDTH),
  localparam int Y_BITS      = $clog2(IMAGE_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 resend,
  input  logic                 start,
  input  logic                 continuous,
  input  logic [X_BITS-1:0]    x0,
  input  logic [X_BITS-1:0]    x1,
  input  logic [Y_BITS-1:0]    y0,
  input  logic [Y_BITS-1:0]    y1,
  input  logic [STEP_BITS-1:0] step_x,
  input  logic [STEP_BITS-1:0] step_y,
  input  logic                 ready,
  output logic [ADDR_BITS-1:0] rdaddress,
  output logic [X_BITS-1:0]    col,
  output logic [Y_BITS-1:0]    row,
  output logic                 valid,
  output logic                 sof,
  output logic                 eol,
  output logic                 eof,
  output logic                 busy,
  output logic                 cfg_err
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state_q, state_d;
  logic [X_BITS-1:0]    x0_q, x0_d, x1_q, x1_d, col_q, col_d, load_col;
  logic [Y_BITS-1:0]    y0_q, y0_d, y1_q, y1_d, row_q, row_d, load_row;
  logic [STEP_BITS-1:0] step_x_q, step_x_d, step_y_q, step_y_d;
  logic                 cont_q, cont_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d, addr_calc;
  logic                 valid_q, valid_d, sof_q, sof_d, cfg_err_q, cfg_err_d;
  logic                 load, cfg_bad, row_wrap, row_end;
  logic [X_BITS:0]      col_sum;
  logic [Y_BITS:0]      row_sum;

  // Sums are one bit wider than the coordinates so a step past the edge never wraps.
  assign col_sum  = {1'b0, col_q} + (X_BITS+1)'(step_x_q);
  assign row_sum  = {1'b0, row_q} + (Y_BITS+1)'(step_y_q);
  assign row_wrap = col_sum > {1'b0, x1_q};
  assign row_end  = row_sum > {1'b0, y1_q};

  assign cfg_bad = (x1 < x0) || (y1 < y0) ||
                   ({1'b0, x1} >= (X_BITS+1)'(IMAGE_WIDTH)) ||
                   ({1'b0, y1} >= (Y_BITS+1)'(IMAGE_HEIGHT)) ||
                   (step_x == '0) || (step_y == '0);

  assign addr_calc = ADDR_BITS'(BASE_ADDR) + ADDR_BITS'(load_row) * ADDR_BITS'(IMAGE_WIDTH)
                   + ADDR_BITS'(load_col);

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    step_x_d  = step_x_q;
    step_y_d  = step_y_q;
    cont_d    = cont_q;
    valid_d   = valid_q;
    sof_d     = sof_q;
    cfg_err_d = 1'b0;
    load      = 1'b0;
    load_col  = col_q;
    load_row  = row_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            x0_d     = x0;
            x1_d     = x1;
            y0_d     = y0;
            y1_d     = y1;
            step_x_d = step_x;
            step_y_d = step_y;
            cont_d   = continuous;
            state_d  = SCAN;
            valid_d  = 1'b1;
            sof_d    = 1'b1;
            load     = 1'b1;
            load_col = x0;
            load_row = y0;
          end
        end
      end
      SCAN: begin
        if (resend) begin
          load     = 1'b1;
          load_col = x0_q;
          load_row = y0_q;
          sof_d    = 1'b1;
          valid_d  = 1'b1;
        end else if (valid_q && ready) begin
          sof_d = 1'b0;
          if (!row_wrap) begin
            load     = 1'b1;
            load_col = col_sum[X_BITS-1:0];
          end else if (!row_end) begin
            load     = 1'b1;
            load_col = x0_q;
            load_row = row_sum[Y_BITS-1:0];
          end else if (cont_q) begin
            load     = 1'b1;
            load_col = x0_q;
            load_row = y0_q;
            sof_d    = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    col_d  = load ? load_col  : col_q;
    row_d  = load ? load_row  : row_q;
    addr_d = load ? addr_calc : addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      step_x_q  <= '0;
      step_y_q  <= '0;
      cont_q    <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      y0_q      <= y0_d;
      y1_q      <= y1_d;
      step_x_q  <= step_x_d;
      step_y_q  <= step_y_d;
      cont_q    <= cont_d;
      col_q     <= col_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign rdaddress = addr_q;
  assign col       = col_q;
  assign row       = row_q;
  assign valid     = valid_q;
  assign sof       = sof_q;
  assign eol       = valid_q & row_wrap;
  assign eof       = valid_q & row_wrap & row_end;
  assign busy      = (state_q == SCAN);
  assign cfg_err   = cfg_err_q;

endmodule
